prewish_button_poller: RTL and testbench

//  Sequences the debounced button-status unit. Generates its slow debounce clock, periodically

---
 rtl/prewish_button_poller_pkg.sv | 19 +
 rtl/prewish_button_poller_tick_div.sv | 28 ++
 rtl/prewish_button_poller.sv | 142 ++++++++++++++
 tb/tb_prewish_button_poller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prewish_button_poller_pkg.sv
// Shared types and sizing helpers for the button poller.
package prewish_button_poller_pkg;

  localparam int STATUS_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_WAIT,
    ST_CMP
  } poll_state_t;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prewish_button_poller_tick_div.sv
// Free-running 0..DIV-1 counter; o_wrap is high in the cycle the count equals DIV-1.
module prewish_tick_div
  import prewish_button_poller_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_wrap
);

  localparam int            W    = cnt_w(DIV);
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] r_count;

  // NOTE: reset is sampled on the clock edge (synchronous), so it lives inside the clocked branch.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_wrap = (r_count == LAST);

endmodule

// File: rtl/prewish_button_poller.sv
// Polls the debounced status unit over STB/DAT, generates its debounce clock,
// and publishes the latched status byte plus press/release event pulses.
module prewish_button_poller
  import prewish_button_poller_pkg::*;
#(
  parameter int DB_DIV   = 1000,
  parameter int POLL_DIV = 50000,
  parameter int TIMEOUT  = 16
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  output logic                o_dbclock,
  output logic                STB_O,
  output logic [STATUS_W-1:0] DAT_O,
  input  logic                STB_I,
  input  logic [STATUS_W-1:0] DAT_I,
  output logic [STATUS_W-1:0] o_state,
  output logic [STATUS_W-1:0] o_press,
  output logic [STATUS_W-1:0] o_release,
  output logic                o_event,
  output logic                o_timeout,
  output logic                o_overrun
);

  localparam int                 WAIT_W    = cnt_w(TIMEOUT);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic w_poll_tick;
  logic w_db_wrap;

  poll_state_t         r_fsm;
  logic [WAIT_W-1:0]   r_wait;
  logic [STATUS_W-1:0] r_new;
  logic [STATUS_W-1:0] r_state;
  logic [STATUS_W-1:0] r_press;
  logic [STATUS_W-1:0] r_release;
  logic                r_event;
  logic                r_stb;
  logic                r_timeout;
  logic                r_overrun;
  logic                r_primed;
  logic                r_dbclock;

  prewish_tick_div #(.DIV(POLL_DIV)) u_poll_div (
    .i_clk  (CLK_I),
    .i_rst  (RST_I),
    .o_wrap (w_poll_tick)
  );

  prewish_tick_div #(.DIV(DB_DIV)) u_db_div (
    .i_clk  (CLK_I),
    .i_rst  (RST_I),
    .o_wrap (w_db_wrap)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_dbclock <= 1'b0;
    end else if (w_db_wrap) begin
      r_dbclock <= ~r_dbclock;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_fsm     <= ST_IDLE;
      r_wait    <= '0;
      r_new     <= '0;
      r_state   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_event   <= 1'b0;
      r_stb     <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
      r_primed  <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle and are raised only by the branch that owns them.
      r_stb     <= 1'b0;
      r_press   <= '0;
      r_release <= '0;
      r_event   <= 1'b0;

      // A tick that finds a transaction in flight is dropped, not queued.
      if (w_poll_tick && r_fsm != ST_IDLE) begin
        r_overrun <= 1'b1;
      end

      case (r_fsm)
        ST_IDLE: begin
          if (w_poll_tick) begin
            r_fsm <= ST_REQ;
            r_stb <= 1'b1;
          end
        end
        ST_REQ: begin
          r_fsm <= ST_GAP;
        end
        ST_GAP: begin
          r_fsm  <= ST_WAIT;
          r_wait <= '0;
        end
        ST_WAIT: begin
          if (STB_I) begin
            r_new <= DAT_I;
            r_fsm <= ST_CMP;
          end else if (r_wait == WAIT_LAST) begin
            r_timeout <= 1'b1;
            r_fsm     <= ST_IDLE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ST_CMP: begin
          r_state  <= r_new;
          r_primed <= 1'b1;
          r_fsm    <= ST_IDLE;
          // The first capture after reset only establishes the baseline.
          if (r_primed) begin
            r_press   <= r_new & ~r_state;
            r_release <= ~r_new & r_state;
            r_event   <= |(r_new ^ r_state);
          end
        end
        default: begin
          r_fsm <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_dbclock = r_dbclock;
  assign STB_O     = r_stb;
  assign DAT_O     = {STATUS_W{1'b1}};
  assign o_state   = r_state;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_event   = r_event;
  assign o_timeout = r_timeout;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_prewish_button_poller.sv
// Scoreboard bench: a status-unit model answers polls, a reference model predicts outputs,
// and a negedge monitor compares every cycle.
module tb_prewish_button_poller;

  localparam int DB_DIV   = 2;
  localparam int POLL_DIV = 32;
  localparam int TIMEOUT  = 4;
  localparam int TIMEOUT2 = 64;

  localparam int M_ANS  = 0;
  localparam int M_NONE = 1;
  localparam int M_RST  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, stb_i;
  logic [7:0] dat_i;
  logic       o_dbclock, stb_o, o_event, o_timeout, o_overrun;
  logic [7:0] dat_o, o_state, o_press, o_release;

  logic       rst2, stb_i2;
  logic [7:0] dat_i2;
  logic       o_dbclock2, stb_o2, o_event2, o_timeout2, o_overrun2;
  logic [7:0] dat_o2, o_state2, o_press2, o_release2;

  prewish_button_poller #(.DB_DIV(DB_DIV), .POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT)) dut (
    .CLK_I(clk), .RST_I(rst), .o_dbclock(o_dbclock), .STB_O(stb_o), .DAT_O(dat_o),
    .STB_I(stb_i), .DAT_I(dat_i), .o_state(o_state), .o_press(o_press),
    .o_release(o_release), .o_event(o_event), .o_timeout(o_timeout), .o_overrun(o_overrun)
  );

  prewish_button_poller #(.DB_DIV(DB_DIV), .POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT2)) dut2 (
    .CLK_I(clk), .RST_I(rst2), .o_dbclock(o_dbclock2), .STB_O(stb_o2), .DAT_O(dat_o2),
    .STB_I(stb_i2), .DAT_I(dat_i2), .o_state(o_state2), .o_press(o_press2),
    .o_release(o_release2), .o_event(o_event2), .o_timeout(o_timeout2), .o_overrun(o_overrun2)
  );

  typedef struct {
    int         due;
    logic [7:0] st;
    logic [7:0] pr;
    logic [7:0] rl;
    logic       ev;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         rst_cyc;
  int         exp_to;
  bit         mon_en;
  bit         d2_done;
  logic [7:0] mon_state;
  logic [7:0] m_state;
  bit         m_primed;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard when a capture is due, otherwise expects quiet pulses.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        mon_e = sb.pop_front();
        check("sb_due", cyc, mon_e.due);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        check("state", o_state, mon_e.st);
        check("press", o_press, mon_e.pr);
        check("release", o_release, mon_e.rl);
        check("event", o_event, mon_e.ev);
        mon_state = mon_e.st;
      end else begin
        check("state_hold", o_state, mon_state);
        check("press_idle", o_press, 8'h00);
        check("release_idle", o_release, 8'h00);
        check("event_idle", o_event, 1'b0);
      end
      check("dbclock", o_dbclock, ((cyc - rst_cyc) / DB_DIV) % 2);
      check("timeout", o_timeout, (exp_to >= 0 && cyc >= exp_to));
      check("overrun", o_overrun, 1'b0);
    end
  end

  // One poll: wait for STB_O, then answer after d WAIT cycles, stay silent, or reset mid-WAIT.
  task automatic do_poll(input int mode, input logic [7:0] b, input int d);
    int   s, n;
    bit   seen;
    exp_t e;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (stb_o === 1'b1) seen = 1;
    end
    check("stb_seen", seen, 1'b1);
    if (!seen) return;
    s = cyc;
    check("stb_phase", (s - rst_cyc) % POLL_DIV, 0);
    check("dat_o", dat_o, 8'hFF);
    @(negedge clk);
    check("stb_width", stb_o, 1'b0);
    if (mode == M_ANS) begin
      n = s + 2 + d;
      while (cyc < n - 1) @(negedge clk);
      @(posedge clk); #1;
      stb_i = 1'b1;
      dat_i = b;
      if (d < TIMEOUT) begin
        e.due = n + 2;
        e.st  = b;
        if (!m_primed) begin
          e.pr = 8'h00;
          e.rl = 8'h00;
          e.ev = 1'b0;
          m_primed = 1;
        end else begin
          e.pr = b & ~m_state;
          e.rl = ~b & m_state;
          e.ev = ((e.pr | e.rl) != 8'h00);
        end
        m_state = b;
        sb.push_back(e);
      end else if (exp_to < 0) begin
        exp_to = s + 2 + TIMEOUT;
      end
      @(posedge clk); #1;
      stb_i = 1'b0;
      dat_i = 8'($urandom);
    end else if (mode == M_NONE) begin
      if (exp_to < 0) exp_to = s + 2 + TIMEOUT;
    end else begin
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst       = 1'b0;
      rst_cyc   = cyc;
      sb.delete();
      mon_state = 8'h00;
      exp_to    = -1;
      m_state   = 8'h00;
      m_primed  = 0;
      check("rst_stb", stb_o, 1'b0);
      check("rst_state", o_state, 8'h00);
      check("rst_timeout", o_timeout, 1'b0);
      check("rst_dbclock", o_dbclock, 1'b0);
      @(posedge clk); #1;
      stb_i = 1'b1;
      dat_i = 8'($urandom | 1);
      @(posedge clk); #1;
      stb_i = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] b;
    int         mode;
    rst = 1'b1; stb_i = 1'b0; dat_i = 8'h00;
    mon_en = 0; exp_to = -1; rst_cyc = 0;
    mon_state = 8'h00; m_state = 8'h00; m_primed = 0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    rst_cyc = cyc;
    mon_en  = 1;
    check("reset_state", o_state, 8'h00);
    check("reset_press", o_press, 8'h00);
    check("reset_release", o_release, 8'h00);
    check("reset_event", o_event, 1'b0);
    check("reset_stb", stb_o, 1'b0);
    check("reset_timeout", o_timeout, 1'b0);
    check("reset_overrun", o_overrun, 1'b0);
    check("reset_dbclock", o_dbclock, 1'b0);

    do_poll(M_ANS, 8'h05, 1);
    do_poll(M_ANS, 8'h06, 0);
    do_poll(M_ANS, 8'h06, 3);
    do_poll(M_NONE, 8'h00, 0);
    do_poll(M_ANS, 8'h81, 2);
    do_poll(M_RST, 8'h00, 0);
    do_poll(M_ANS, 8'h3C, 3);
    do_poll(M_ANS, 8'hC3, 0);

    b = 8'hC3;
    for (int k = 0; k < 20; k++) begin
      mode = ($urandom_range(0, 5) == 0) ? M_NONE : M_ANS;
      if ($urandom_range(0, 3) != 0) b = 8'($urandom);
      do_poll(mode, b, $urandom_range(0, 5));
    end

    repeat (10) @(posedge clk);
    check("sb_drain", sb.size(), 0);
    for (int i = 0; i < 2000 && !d2_done; i++) @(posedge clk);
    check("dut2_done", d2_done, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Second instance with a long wait window: a slow answer lets the next tick hit a busy FSM.
  initial begin : overrun_blk
    int s;
    int highs;
    bit seen;
    rst2 = 1'b1; stb_i2 = 1'b0; dat_i2 = 8'h00; d2_done = 0;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (stb_o2 === 1'b1) seen = 1;
    end
    check("ovr_stb_seen", seen, 1'b1);
    s = cyc;
    highs = 0;
    for (int c = s + 1; c <= s + 63; c++) begin
      @(posedge clk); #1;
      if (stb_o2 !== 1'b0) highs++;
      stb_i2 = (c == s + 40);
      dat_i2 = (c == s + 40) ? 8'hA5 : 8'h00;
      if (c == s + 31) check("ovr_before", o_overrun2, 1'b0);
      if (c == s + 32) check("ovr_set", o_overrun2, 1'b1);
      if (c == s + 42) begin
        check("ovr_state", o_state2, 8'hA5);
        check("ovr_event", o_event2, 1'b0);
      end
    end
    check("ovr_no_stb", highs, 0);
    @(posedge clk); #1;
    check("ovr_next_stb", stb_o2, 1'b1);
    check("ovr_timeout", o_timeout2, 1'b0);
    check("ovr_sticky", o_overrun2, 1'b1);
    d2_done = 1;
  end

endmodule
